fetch_pc_predict: RTL and testbench
===================================

# fetch_pc_predict

Fetch-stage next-PC unit that owns the IF program counter and consumes the BTB's `branch_address` each cycle. It holds a 2-bit saturating direction table indexed like the BTB and chooses between the BTB target and sequential PC+2. It also detects mispredictions when control instructions reach WB, redirects fetch, and keeps prediction statistics.

## Interface
Parameters:
- `LINES`, 32: direction-table entries; index is `pc[5:1]`, the same indexing as the BTB.
- `RESET_PC`, 16'h0000: value loaded into the PC on reset.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stall_if`, in, 1: holds the PC.
- `btb_target`, in, 16: BTB `branch_address` for `pc_if`. It equals `pc_if` on a BTB miss.
- `pc_if`, out, 16: registered fetch PC, also driven to the BTB.
- `pred_taken_if`, out, 1: taken prediction for the instruction at `pc_if`.
- `pred_target_if`, out, 16: predicted next PC. Carried down the pipe with `pred_taken_if`.
- `is_valid_inst_wb`, in, 1: WB holds a real instruction, not a bubble.
- `opcode_wb`, in, 4: WB opcode.
- `pc_wb`, in, 16: WB instruction PC.
- `taken_wb`, in, 1: resolved outcome. Forced to 1 for JMP/JSR/TRAP.
- `target_wb`, in, 16: resolved target. For TRAP this is the memory vector.
- `pred_taken_wb`, in, 1: `pred_taken_if` as staged down to WB.
- `pred_target_wb`, in, 16: `pred_target_if` as staged down to WB.
- `flush`, out, 1: misprediction redirect; kills IF..MEM.
- `branch_count`, out, 16: count of resolved control instructions.
- `mispredict_count`, out, 16: count of redirects.

## Operation
- **Control opcodes:** BR 4'b0000, JMP 4'b1100, JSR 4'b0100, TRAP 4'b1111.
- **WB event:** `ctrl_wb = is_valid_inst_wb & opcode ∈ {BR, JMP, JSR, TRAP}`.
- **BTB hit:** `btb_hit = (btb_target != pc_if)`.
- **Prediction:**
  - `pred_taken_if = btb_hit & ctr[pc_if[5:1]][1]`.
  - `pred_target_if = pred_taken_if ? btb_target : pc_if + 2`.
  - Both are combinational and read the stored counter value, with no bypass of a same-cycle WB update.
- **Actual outcome:**
  - `act_taken = ctrl_wb & taken_wb`.
  - `act_next = act_taken ? target_wb : pc_wb + 2`.
- **Misprediction:**
  - `flush = is_valid_inst_wb & ((pred_taken_wb != act_taken) | (act_taken & pred_target_wb != target_wb))`.
  - Any valid non-control instruction predicted taken therefore flushes to `pc_wb + 2`.
- **Next PC priority** (highest first):
  1. `flush`: load `act_next`. This overrides `stall_if`.
  2. `stall_if`: hold.
  3. Otherwise: load `pred_target_if`.
- **PC arithmetic:** all PC adds are 16-bit and wrap modulo 2^16, so 16'hFFFE + 2 = 16'h0000.
- **Counter update:** on `ctrl_wb`, `ctr[pc_wb[5:1]]` increments (saturating at 2'b11) if `act_taken`, else decrements (saturating at 2'b00). Bubbles and non-control instructions never update.
- **Statistics:**
  - `branch_count` increments on `ctrl_wb`.
  - `mispredict_count` increments on `flush`.
  - Both saturate at 16'hFFFF. Both may increment in the same cycle.
- **Reset values:**
  - `pc_if = RESET_PC`.
  - All counters = 2'b01 (weakly not-taken).
  - `branch_count = mispredict_count = 0`.
  - `pred_taken_if` follows from the reset state and `btb_target`. `flush` follows from the WB inputs.

## Timing
- `pc_if`, the counters and the statistics are registered on posedge `clk`. Reset acts asynchronously on assertion.
- **Reset mid-operation:** `pc_if` becomes `RESET_PC` immediately, with no wait for a clock edge. The first update occurs on the first posedge after `rst_n` rises.
- **`flush` latency:** `flush` is combinational in the same cycle the mispredicted instruction sits in WB. `pc_if = act_next` on the next edge, which is 1-cycle redirect latency.
- **Counter latency:** a counter update is visible to prediction starting the cycle after the WB edge.
- **Prediction path:** `btb_target` → `pred_target_if` → PC register is a single-cycle combinational path with no pipeline register.
- **Simultaneous stall and flush:** redirect wins. The pipeline controller owns squashing of the stalled IF instruction.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=16'h3000, deassert, `btb_target` = `pc_if`, no stalls → `pc_if` reads 3000, 3002, 3004; `pred_taken_if` = 0 and `flush` = 0 throughout.
- **Training a taken BR:** BR at 16'h3010 resolves taken to 16'h3020 twice in WB, with `pred_taken_wb` = 0 both times.
  - Each resolution raises `flush` for one cycle and the next `pc_if` is 16'h3020.
  - The counter goes 01 → 10 → 11 and `mispredict_count` = 2.
  - Next fetch of 16'h3010 with `btb_target` = 16'h3020 → `pred_taken_if` = 1 and `pc_if` = 16'h3020 on the next cycle.
- **Counter saturation:** 5 not-taken resolutions of a BR at 16'h3010 → counter stops at 00 and `pred_taken_if` = 0 even on a BTB hit; 5 taken resolutions stop at 11.
- **Wrong target:** JMP predicted taken to 16'h4000 but `target_wb` = 16'h5000 → `flush` = 1 and `pc_if` = 16'h5000 next cycle; `branch_count` and `mispredict_count` each +1.
- **Flush over stall:** `stall_if` = 1 while a WB misprediction with `act_next` = 16'h6000 is present → `pc_if` = 16'h6000 next edge. With `stall_if` = 1 and no flush, `pc_if` holds.
- **Bubble and wrap:** a bubble at WB (`is_valid_inst_wb` = 0) with `pred_taken_wb` = 1 → no flush, no counter or statistic change. Separately, `pc_if` = 16'hFFFE with no prediction → next `pc_if` = 16'h0000.

Source files
------------

// File: rtl/fetch_pc_predict.sv
// rtl/fetch_pc_predict.sv - fetch next-PC unit with 2-bit direction table, WB misprediction redirect and statistics
module fetch_pc_predict #(
    parameter int unsigned LINES    = 32,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic [15:0] btb_target,
    output logic [15:0] pc_if,
    output logic        pred_taken_if,
    output logic [15:0] pred_target_if,
    input  logic        is_valid_inst_wb,
    input  logic [3:0]  opcode_wb,
    input  logic [15:0] pc_wb,
    input  logic        taken_wb,
    input  logic [15:0] target_wb,
    input  logic        pred_taken_wb,
    input  logic [15:0] pred_target_wb,
    output logic        flush,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(LINES);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [15:0]      pc_q, pc_d;
    logic [1:0]       ctr_q [LINES];
    logic [15:0]      bc_q, bc_d;
    logic [15:0]      mc_q, mc_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] wb_idx;
    logic             btb_hit;
    logic             ctrl_wb;
    logic             act_taken;
    logic [15:0]      act_next;
    logic [1:0]       ctr_wb;

    assign if_idx = pc_q[IDX_W:1];
    assign wb_idx = pc_wb[IDX_W:1];

    // The BTB reports a miss by echoing the fetch PC back.
    assign btb_hit        = (btb_target != pc_q);
    assign pred_taken_if  = btb_hit & ctr_q[if_idx][1];
    assign pred_target_if = pred_taken_if ? btb_target : pc_q + 16'd2;

    assign ctrl_wb   = is_valid_inst_wb &
                       ((opcode_wb == OP_BR)  | (opcode_wb == OP_JMP) |
                        (opcode_wb == OP_JSR) | (opcode_wb == OP_TRAP));
    assign act_taken = ctrl_wb & taken_wb;
    assign act_next  = act_taken ? target_wb : pc_wb + 16'd2;

    assign flush = is_valid_inst_wb &
                   ((pred_taken_wb != act_taken) |
                    (act_taken & (pred_target_wb != target_wb)));

    assign ctr_wb = ctr_q[wb_idx];

    always_comb begin
        pc_d = pc_q;
        bc_d = bc_q;
        mc_d = mc_q;
        // Redirect beats a stall; the pipeline controller squashes the stalled fetch.
        if (flush) begin
            pc_d = act_next;
        end else if (!stall_if) begin
            pc_d = pred_target_if;
        end
        if (ctrl_wb && (bc_q != 16'hFFFF)) begin
            bc_d = bc_q + 16'd1;
        end
        if (flush && (mc_q != 16'hFFFF)) begin
            mc_d = mc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            bc_q <= 16'h0000;
            mc_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            bc_q <= bc_d;
            mc_q <= mc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LINES); i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (ctrl_wb) begin
            if (act_taken) begin
                if (ctr_wb != 2'b11) begin
                    ctr_q[wb_idx] <= ctr_wb + 2'd1;
                end
            end else if (ctr_wb != 2'b00) begin
                ctr_q[wb_idx] <= ctr_wb - 2'd1;
            end
        end
    end

    assign pc_if            = pc_q;
    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// tb/tb_fetch_pc_predict.sv - directed and randomized check of fetch_pc_predict against a behavioural model
module tb_fetch_pc_predict;

    logic        clk;
    logic        rst_n;
    logic        stall_if;
    logic [15:0] btb_target;
    logic [15:0] pc_if;
    logic        pred_taken_if;
    logic [15:0] pred_target_if;
    logic        is_valid_inst_wb;
    logic [3:0]  opcode_wb;
    logic [15:0] pc_wb;
    logic        taken_wb;
    logic [15:0] target_wb;
    logic        pred_taken_wb;
    logic [15:0] pred_target_wb;
    logic        flush;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int vectors;
    int miscompares;

    // Reference model state
    logic [15:0] m_pc;
    int          m_ctr [32];
    int          m_bc;
    int          m_mc;

    fetch_pc_predict #(.LINES(32), .RESET_PC(16'h3000)) dut (
        .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .btb_target(btb_target),
        .pc_if(pc_if), .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .is_valid_inst_wb(is_valid_inst_wb), .opcode_wb(opcode_wb), .pc_wb(pc_wb),
        .taken_wb(taken_wb), .target_wb(target_wb), .pred_taken_wb(pred_taken_wb),
        .pred_target_wb(pred_target_wb), .flush(flush), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h3000;
        for (int i = 0; i < 32; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    function automatic bit is_ctrl_op(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd12) || (op == 4'd4) || (op == 4'd15);
    endfunction

    task automatic wb_none();
        is_valid_inst_wb = 1'b0;
        opcode_wb        = 4'd1;
        pc_wb            = 16'h0000;
        taken_wb         = 1'b0;
        target_wb        = 16'h0000;
        pred_taken_wb    = 1'b0;
        pred_target_wb   = 16'h0000;
    endtask

    task automatic wb_set(input logic v, input logic [3:0] op, input logic [15:0] pcw,
                          input logic tk, input logic [15:0] tgt,
                          input logic ptk, input logic [15:0] ptgt);
        is_valid_inst_wb = v;
        opcode_wb        = op;
        pc_wb            = pcw;
        taken_wb         = tk;
        target_wb        = tgt;
        pred_taken_wb    = ptk;
        pred_target_wb   = ptgt;
    endtask

    // Called at a negedge with inputs driven; checks everything, advances one clock, updates model.
    task automatic tick();
        logic        e_hit, e_pt, e_ctrl, e_at, e_fl;
        logic [15:0] e_ptg, e_an;
        logic [15:0] wbp;
        int          fi, wi;
        #1;
        fi     = int'(m_pc[5:1]);
        e_hit  = (btb_target != m_pc);
        e_pt   = e_hit && (m_ctr[fi] >= 2);
        e_ptg  = e_pt ? btb_target : m_pc + 16'd2;
        e_ctrl = is_valid_inst_wb && is_ctrl_op(opcode_wb);
        e_at   = e_ctrl && taken_wb;
        e_an   = e_at ? target_wb : pc_wb + 16'd2;
        e_fl   = is_valid_inst_wb && ((pred_taken_wb != e_at) || (e_at && (pred_target_wb != target_wb)));
        chk16("pc_if", pc_if, m_pc);
        chk1("pred_taken_if", pred_taken_if, e_pt);
        chk16("pred_target_if", pred_target_if, e_ptg);
        chk1("flush", flush, e_fl);
        chk16("branch_count", branch_count, 16'(m_bc));
        chk16("mispredict_count", mispredict_count, 16'(m_mc));
        wbp = pc_wb;
        wi  = int'(wbp[5:1]);
        @(posedge clk);
        if (e_fl) m_pc = e_an;
        else if (!stall_if) m_pc = e_ptg;
        if (e_ctrl) begin
            if (e_at) m_ctr[wi] = (m_ctr[wi] < 3) ? m_ctr[wi] + 1 : 3;
            else      m_ctr[wi] = (m_ctr[wi] > 0) ? m_ctr[wi] - 1 : 0;
            if (m_bc < 65535) m_bc++;
        end
        if (e_fl && m_mc < 65535) m_mc++;
        @(negedge clk);
    endtask

    // Force fetch to a given PC through a mispredicted JMP from a PC whose table entry is unused here.
    task automatic redirect_to(input logic [15:0] dest);
        stall_if   = 1'b0;
        btb_target = m_pc;
        wb_set(1'b1, 4'd12, 16'h3100, 1'b1, dest, 1'b0, 16'h3102);
        tick();
        wb_none();
    endtask

    initial begin
        int snap_bc, snap_mc;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        stall_if    = 1'b0;
        btb_target  = 16'h3000;
        wb_none();
        model_reset();

        repeat (2) @(negedge clk);
        chk16("reset_pc", pc_if, 16'h3000);
        chk16("reset_bc", branch_count, 16'h0000);
        chk16("reset_mc", mispredict_count, 16'h0000);
        chk1("reset_flush", flush, 1'b0);
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 3; i++) begin
            btb_target = m_pc;
            chk16("seq_pc", pc_if, 16'h3000 + 16'(2 * i));
            tick();
        end

        // Train a taken BR at 3010 -> 3020
        for (int k = 0; k < 2; k++) begin
            btb_target = m_pc;
            wb_set(1'b1, 4'd0, 16'h3010, 1'b1, 16'h3020, 1'b0, 16'h3012);
            #1 chk1("train_flush", flush, 1'b1);
            tick();
            chk16("train_pc", pc_if, 16'h3020);
        end
        wb_none();
        chk16("train_bc", branch_count, 16'd2);
        chk16("train_mc", mispredict_count, 16'd2);
        redirect_to(16'h3010);
        chk16("redir_pc", pc_if, 16'h3010);
        btb_target = 16'h3020;
        #1 chk1("trained_pred", pred_taken_if, 1'b1);
        tick();
        chk16("trained_pc", pc_if, 16'h3020);

        // Saturate toward not-taken
        for (int k = 0; k < 5; k++) begin
            btb_target = m_pc;
            wb_set(1'b1, 4'd0, 16'h3010, 1'b0, 16'h3020, 1'b0, 16'h3012);
            tick();
        end
        redirect_to(16'h3010);
        btb_target = 16'h3020;
        #1 chk1("sat_nt_pred", pred_taken_if, 1'b0);
        chk16("sat_nt_tgt", pred_target_if, 16'h3012);
        tick();

        // Saturate toward taken, then one not-taken must still predict taken
        for (int k = 0; k < 6; k++) begin
            btb_target = m_pc;
            if (k < 5) wb_set(1'b1, 4'd0, 16'h3010, 1'b1, 16'h3020, 1'b1, 16'h3020);
            else       wb_set(1'b1, 4'd0, 16'h3010, 1'b0, 16'h3020, 1'b0, 16'h3012);
            tick();
        end
        redirect_to(16'h3010);
        btb_target = 16'h3020;
        #1 chk1("sat_t_pred", pred_taken_if, 1'b1);
        tick();

        // Wrong target
        snap_bc    = m_bc;
        snap_mc    = m_mc;
        btb_target = m_pc;
        wb_set(1'b1, 4'd12, 16'h3200, 1'b1, 16'h5000, 1'b1, 16'h4000);
        #1 chk1("wrong_tgt_flush", flush, 1'b1);
        tick();
        chk16("wrong_tgt_pc", pc_if, 16'h5000);
        chk16("wrong_tgt_bc", branch_count, 16'(snap_bc + 1));
        chk16("wrong_tgt_mc", mispredict_count, 16'(snap_mc + 1));

        // Flush over stall, then plain stall holds
        stall_if   = 1'b1;
        btb_target = m_pc;
        wb_set(1'b1, 4'd0, 16'h3300, 1'b1, 16'h6000, 1'b0, 16'h3302);
        tick();
        chk16("flush_stall_pc", pc_if, 16'h6000);
        wb_none();
        btb_target = m_pc;
        tick();
        chk16("stall_hold_pc", pc_if, 16'h6000);
        stall_if = 1'b0;

        // Bubble with stale prediction
        snap_bc    = m_bc;
        snap_mc    = m_mc;
        btb_target = m_pc;
        wb_set(1'b0, 4'd0, 16'h3010, 1'b1, 16'h7000, 1'b1, 16'h7000);
        #1 chk1("bubble_flush", flush, 1'b0);
        tick();
        chk16("bubble_bc", branch_count, 16'(snap_bc));
        chk16("bubble_mc", mispredict_count, 16'(snap_mc));

        // PC wrap
        redirect_to(16'hFFFE);
        chk16("wrap_pre", pc_if, 16'hFFFE);
        btb_target = m_pc;
        tick();
        chk16("wrap_pc", pc_if, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] op;
            logic [15:0] tgt;
            stall_if   = ($urandom_range(0, 3) == 0);
            btb_target = ($urandom_range(0, 1) == 0) ? m_pc : {16'($urandom) & 16'hFFFE};
            case ($urandom_range(0, 4))
                0: op = 4'd0;
                1: op = 4'd12;
                2: op = 4'd4;
                3: op = 4'd15;
                default: op = 4'($urandom);
            endcase
            tgt = 16'($urandom) & 16'hFFFE;
            wb_set(1'($urandom_range(0, 1)), op, 16'h3000 + 16'(2 * $urandom_range(0, 40)),
                   (op == 4'd12 || op == 4'd4 || op == 4'd15) ? 1'b1 : 1'($urandom_range(0, 1)),
                   tgt, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 0) ? tgt : (16'($urandom) & 16'hFFFE));
            tick();
        end

        // Asynchronous reset mid-operation
        stall_if   = 1'b0;
        btb_target = m_pc;
        wb_set(1'b1, 4'd0, 16'h3010, 1'b1, 16'h3020, 1'b0, 16'h3012);
        #2 rst_n = 1'b0;
        #1;
        chk16("async_rst_pc", pc_if, 16'h3000);
        chk16("async_rst_bc", branch_count, 16'h0000);
        chk16("async_rst_mc", mispredict_count, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wb_none();
        for (int i = 0; i < 4; i++) begin
            btb_target = m_pc;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
